ram_access_ctrl: RTL and testbench

- Request-side controller and 4-word storage array for the 4x4 RAM.
- Accepts single-word read/write requests over a valid/ready handshake and drives the two-bit address plus enable into the 2-to-4 word decoder.
- Consumes the decoder's four one-hot word selects (sel_i) and uses them to write or read the addressed word.
- Returns read data, or a write acknowledge, over a valid/ready response channel.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_word_reg.sv | 16 +
 rtl/ram_access_ctrl.sv | 90 +++++++++
 tb/tb_ram_access_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM states, sizes and one-hot select codes for the 4x4 RAM controller
package ram_pkg;
   localparam int ADDR_W    = 2;
   localparam int NUM_WORDS = 4;
   localparam logic [NUM_WORDS-1:0] SEL_W0 = 4'b0001;
   localparam logic [NUM_WORDS-1:0] SEL_W1 = 4'b0010;
   localparam logic [NUM_WORDS-1:0] SEL_W2 = 4'b0100;
   localparam logic [NUM_WORDS-1:0] SEL_W3 = 4'b1000;
   typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;
   function automatic logic [NUM_WORDS-1:0] addr_to_sel(input logic [ADDR_W-1:0] a);
      return SEL_W0 << a;
   endfunction
endpackage

// File: rtl/ram_word_reg.sv
// ram_word_reg: one storage word with async reset to RESET_VAL and a load enable
module ram_word_reg #(
   parameter int DATA_W = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);
   // word storage, overwritten only when its select loads it
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) o_q <= RESET_VAL;
      else if (i_load) o_q <= i_d;
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: request/response controller and 4-word array driving an external 2-to-4 decoder; RAM_SEL_CHECK_EN enables select-fault checking
module ram_access_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic [DATA_W-1:0]    req_wdata_i,
   output logic                 dec_a_o,
   output logic                 dec_b_o,
   output logic                 dec_en_o,
   input  logic [NUM_WORDS-1:0] sel_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DATA_W-1:0]    rsp_rdata_o,
   output logic                 rsp_err_o
);
   state_t                r_state, w_next;
   logic                  r_we, r_err, w_fault;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata, r_rdata, w_rd_or;
   logic [NUM_WORDS-1:0]  w_load;
   logic [DATA_W-1:0]     w_word [NUM_WORDS];

`ifdef RAM_SEL_CHECK_EN
   assign w_fault = sel_i != addr_to_sel(r_addr);
`else
   assign w_fault = 1'b0;
`endif

   assign w_load      = (r_state == DECODE && r_we && !w_fault) ? sel_i : '0;
   assign dec_a_o     = r_addr[1];
   assign dec_b_o     = r_addr[0];
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;

   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
      ram_word_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_word (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .i_load(w_load[k]),
         .i_d   (r_wdata),
         .o_q   (w_word[k])
      );
   end

   // read value is the OR of every selected word
   always_comb begin
      w_rd_or = '0;
      for (int i = 0; i < NUM_WORDS; i++) w_rd_or = w_rd_or | (sel_i[i] ? w_word[i] : '0);
   end

   // next state and handshake/decoder-enable outputs
   always_comb begin
      w_next      = r_state == IDLE   ? (req_valid_i ? DECODE : IDLE) :
                    r_state == DECODE ? RESP :
                    r_state == RESP   ? (rsp_ready_i ? IDLE : RESP) : IDLE;
      req_ready_o = r_state == IDLE;
      dec_en_o    = r_state == DECODE;
      rsp_valid_o = r_state == RESP;
   end

   // state register, request latch and response capture at the end of DECODE
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= RESET_VAL;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req_valid_i) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
         end
         if (r_state == DECODE) begin
            r_rdata <= (r_we || w_fault) ? '0 : w_rd_or;
            r_err   <= w_fault;
         end
      end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: randomized self-checking bench with an array-level reference model of the RAM
module tb_ram_access_ctrl;
`ifdef RAM_SEL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic       clk_i = 1'b0, rst_i = 1'b1;
   logic       req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
   logic [1:0] req_addr_i = '0;
   logic [3:0] req_wdata_i = '0;
   logic       req_ready_o, dec_a_o, dec_b_o, dec_en_o, rsp_valid_o, rsp_err_o;
   logic [3:0] rsp_rdata_o, sel_i, sel_force = '0;
   logic       force_en = 1'b0;
   logic [3:0] mem [4];
   int         n_checks = 0, n_errors = 0;

   always #5 clk_i = ~clk_i;

   // behavioural 2-to-4 decoder, optionally overridden to inject select faults
   assign sel_i = force_en ? sel_force : (dec_en_o ? 4'b0001 << {dec_a_o, dec_b_o} : 4'b0000);

   ram_access_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .dec_a_o(dec_a_o), .dec_b_o(dec_b_o), .dec_en_o(dec_en_o), .sel_i(sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready_o, 1);
      check({tag, "_dec"}, {dec_a_o, dec_b_o, dec_en_o}, 0);
      check({tag, "_valid"}, rsp_valid_o, 0);
      check({tag, "_rdata"}, rsp_rdata_o, 0);
      check({tag, "_err"}, rsp_err_o, 0);
   endtask

   // one full transaction; fe/fs override the decoder, hold = cycles with rsp_ready_i low
   task automatic txn(input logic we, input logic [1:0] addr, input logic [3:0] wd,
                      input logic fe, input logic [3:0] fs, input int hold);
      logic [3:0] s, exp_rd;
      logic       fault;
      check("idle_ready", req_ready_o, 1);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
      @(posedge clk_i); #1;
      req_valid_i = 1'(($urandom)); req_we_i = 1'($urandom);
      req_addr_i = 2'($urandom); req_wdata_i = 4'($urandom); rsp_ready_i = 1'($urandom);
      force_en = fe; sel_force = fs;
      check("decode_en", dec_en_o, 1);
      check("decode_ab", {dec_a_o, dec_b_o}, addr);
      check("decode_ready", req_ready_o, 0);
      check("decode_valid", rsp_valid_o, 0);
      s = fe ? fs : 4'(1 << addr);
      fault = CHK && s != 4'(1 << addr);
      exp_rd = 0;
      if (we && !fault) begin
         for (int k = 0; k < 4; k++) if (s[k]) mem[k] = wd;
      end else if (!we && !fault) begin
         for (int k = 0; k < 4; k++) if (s[k]) exp_rd |= mem[k];
      end
      @(posedge clk_i); #1;
      force_en = 1'b0;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         check("resp_valid", rsp_valid_o, 1);
         check("resp_rdata", rsp_rdata_o, exp_rd);
         check("resp_err", rsp_err_o, fault);
         check("resp_ready_low", req_ready_o, 0);
         check("resp_dec_off", dec_en_o, 0);
         if (i < hold) begin
            req_valid_i = 1'($urandom); req_we_i = 1'b1;
            req_addr_i = 2'($urandom); req_wdata_i = 4'($urandom);
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
         end
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      check("ack_valid", rsp_valid_o, 0);
      check("ack_ready", req_ready_o, 1);
      rsp_ready_i = 1'($urandom);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) mem[k] = 0;
      #2 check_reset_outputs("reset");
      @(posedge clk_i); #1 rst_i = 1'b0;
      check_reset_outputs("post_reset");
      txn(1'b0, 2'd2, 4'h0, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd1, 4'hA, 1'b0, 4'h0, 0);
      txn(1'b0, 2'd1, 4'h0, 1'b0, 4'h0, 0);
      for (int a = 0; a < 4; a++) if (a != 1) txn(1'b0, 2'(a), 4'h0, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd0, 4'h5, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd1, 4'h3, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd2, 4'hC, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd3, 4'hF, 1'b0, 4'h0, 0);
      for (int a = 0; a < 4; a++) txn(1'b0, 2'(a), 4'h0, 1'b0, 4'h0, 0);
      txn(1'b0, 2'd2, 4'h0, 1'b0, 4'h0, 5);
      // reset during DECODE of a write: array cleared, no response
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 2'd3; req_wdata_i = 4'h9;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      check("pre_rst_decode", dec_en_o, 1);
      rst_i = 1'b1;
      #1 check_reset_outputs("mid_rst");
      for (int k = 0; k < 4; k++) mem[k] = 0;
      @(posedge clk_i); #1 check("rst_hold_valid", rsp_valid_o, 0);
      #3 rst_i = 1'b0;
      @(posedge clk_i); #1;
      txn(1'b0, 2'd3, 4'h0, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd0, 4'h2, 1'b0, 4'h0, 0);
      txn(1'b1, 2'd0, 4'h6, 1'b1, 4'b0011, 0);
      txn(1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 0);
      txn(1'b0, 2'd1, 4'h0, 1'b0, 4'h0, 0);
      for (int n = 0; n < 200; n++) begin
         logic fe;
         fe = ($urandom_range(7) == 0);
         txn(1'($urandom), 2'($urandom), 4'($urandom), fe, 4'($urandom), $urandom_range(3));
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
